// File: rtl/lenet_accelerator.sv
// LeNet-style inference engine over one 28x28 image: conv/ReLU/pool twice, conv3/ReLU, then a 10x10 FC layer.
// Each cycle produces one complete 5x5 window sum (or one full FC row), accumulated across input channels.
//
// state | meaning
// IDLE  | waiting for start
// CONV1 | 28x28x2 same-padded convolution of the image, ReLU
// POOL1 | 2x2 max pool -> 14x14x2
// CONV2 | valid convolution over both channels -> 10x10x2, ReLU
// POOL2 | 2x2 max pool -> 5x5x2
// CONV3 | full 5x5 window over both channels -> 10 scalars, ReLU
// FC    | 10x10 matrix-vector product, no activation
// DONE  | publish output_vector, pulse done, return to IDLE
module lenet_accelerator #(
  parameter int bitwidth  = 32,
  parameter int FRAC_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [bitwidth-1:0] image          [27:0][27:0],
  input  logic signed [bitwidth-1:0] conv1_kernel   [1:0][4:0][4:0],
  input  logic signed [bitwidth-1:0] conv2_kernel   [1:0][1:0][4:0][4:0],
  input  logic signed [bitwidth-1:0] conv3_kernel   [9:0][1:0][4:0][4:0],
  input  logic signed [bitwidth-1:0] connect_matrix [9:0][9:0],
  output logic signed [bitwidth-1:0] output_vector  [9:0],
  output logic                       busy,
  output logic                       done
);
  typedef logic signed [bitwidth-1:0]   data_t;
  typedef logic signed [2*bitwidth-1:0] prod_t;
  typedef logic signed [2*bitwidth+7:0] acc_t;
  typedef enum logic [2:0] {IDLE, CONV1, POOL1, CONV2, POOL2, CONV3, FC, DONE} state_t;

  localparam acc_t SMAX = (acc_t'(1) <<< (bitwidth - 1)) - acc_t'(1);
  localparam acc_t SMIN = -SMAX - acc_t'(1);

  state_t     state, state_nxt;
  logic [3:0] och;
  logic       ich;
  logic [4:0] row, col;
  acc_t       acc, win, total;
  data_t      res, pool_max;
  logic [4:0] dim;
  logic [3:0] omax;
  logic       use_ic, ic_wrap, col_wrap, row_wrap, last;

  data_t c1  [2][28][28];
  data_t p1  [2][14][14];
  data_t c2  [2][10][10];
  data_t p2  [2][5][5];
  data_t c3  [9:0];
  data_t fco [9:0];

  function automatic data_t sat(input acc_t a);
    acc_t sh;
    sh = a >>> FRAC_BITS;
    if (sh > SMAX) return data_t'(SMAX);
    if (sh < SMIN) return data_t'(SMIN);
    return data_t'(sh);
  endfunction

  function automatic data_t relu(input data_t a);
    return a[bitwidth-1] ? data_t'(0) : a;
  endfunction

  function automatic data_t max2(input data_t a, input data_t b);
    return (a > b) ? a : b;
  endfunction

  // 25 parallel taps; FC reuses the first 10 slots for one matrix row
  always_comb begin
    data_t pix, wt;
    int    ir, jc, idx;
    win = '0;
    for (int kr = 0; kr < 5; kr++) begin
      for (int kc = 0; kc < 5; kc++) begin
        pix = '0;
        wt  = '0;
        ir  = int'(row) + kr - 2;
        jc  = int'(col) + kc - 2;
        idx = kr * 5 + kc;
        case (state)
          CONV1: begin
            if (ir >= 0 && ir < 28 && jc >= 0 && jc < 28) pix = image[ir[4:0]][jc[4:0]];
            wt = conv1_kernel[och[0]][kr[2:0]][kc[2:0]];
          end
          CONV2: begin
            pix = p1[ich][4'(row) + 4'(kr)][4'(col) + 4'(kc)];
            wt  = conv2_kernel[och[0]][ich][kr[2:0]][kc[2:0]];
          end
          CONV3: begin
            pix = p2[ich][kr[2:0]][kc[2:0]];
            wt  = conv3_kernel[och][ich][kr[2:0]][kc[2:0]];
          end
          FC: begin
            if (idx < 10) begin
              pix = c3[idx[3:0]];
              wt  = connect_matrix[och][idx[3:0]];
            end
          end
          default: ;
        endcase
        win = win + acc_t'(prod_t'(pix) * prod_t'(wt));
      end
    end
  end

  assign total = acc + win;
  assign res   = sat(total);

  always_comb begin
    pool_max = '0;
    if (state == POOL1)
      pool_max = max2(max2(c1[och[0]][{row[3:0], 1'b0}][{col[3:0], 1'b0}],
                           c1[och[0]][{row[3:0], 1'b0}][{col[3:0], 1'b1}]),
                      max2(c1[och[0]][{row[3:0], 1'b1}][{col[3:0], 1'b0}],
                           c1[och[0]][{row[3:0], 1'b1}][{col[3:0], 1'b1}]));
    else if (state == POOL2)
      pool_max = max2(max2(c2[och[0]][{row[2:0], 1'b0}][{col[2:0], 1'b0}],
                           c2[och[0]][{row[2:0], 1'b0}][{col[2:0], 1'b1}]),
                      max2(c2[och[0]][{row[2:0], 1'b1}][{col[2:0], 1'b0}],
                           c2[och[0]][{row[2:0], 1'b1}][{col[2:0], 1'b1}]));
  end

  // loop bounds per layer: ich innermost, then col, row, och
  always_comb begin
    dim    = 5'd1;
    omax   = 4'd0;
    use_ic = 1'b0;
    case (state)
      CONV1: begin dim = 5'd28; omax = 4'd1; end
      POOL1: begin dim = 5'd14; omax = 4'd1; end
      CONV2: begin dim = 5'd10; omax = 4'd1; use_ic = 1'b1; end
      POOL2: begin dim = 5'd5;  omax = 4'd1; end
      CONV3: begin omax = 4'd9; use_ic = 1'b1; end
      FC:    omax = 4'd9;
      default: ;
    endcase
    ic_wrap  = !use_ic || ich;
    col_wrap = (col == dim - 5'd1);
    row_wrap = (row == dim - 5'd1);
    last     = ic_wrap && col_wrap && row_wrap && (och == omax);
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = CONV1;
      CONV1:   if (last) state_nxt = POOL1;
      POOL1:   if (last) state_nxt = CONV2;
      CONV2:   if (last) state_nxt = POOL2;
      POOL2:   if (last) state_nxt = CONV3;
      CONV3:   if (last) state_nxt = FC;
      FC:      if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      och           <= '0;
      ich           <= 1'b0;
      row           <= '0;
      col           <= '0;
      acc           <= '0;
      done          <= 1'b0;
      output_vector <= '{default: '0};
    end else begin
      state <= state_nxt;
      done  <= (state == DONE);
      if (state == DONE) output_vector <= fco;
      if (state == IDLE || last) begin
        och <= '0;
        ich <= 1'b0;
        row <= '0;
        col <= '0;
        acc <= '0;
      end else if (!ic_wrap) begin
        ich <= 1'b1;
        acc <= total;
      end else begin
        ich <= 1'b0;
        acc <= '0;
        if (!col_wrap) col <= col + 5'd1;
        else begin
          col <= '0;
          if (!row_wrap) row <= row + 5'd1;
          else begin
            row <= '0;
            och <= och + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      CONV1: c1[och[0]][row][col] <= relu(res);
      POOL1: p1[och[0]][row[3:0]][col[3:0]] <= pool_max;
      CONV2: if (ic_wrap) c2[och[0]][row[3:0]][col[3:0]] <= relu(res);
      POOL2: p2[och[0]][row[2:0]][col[2:0]] <= pool_max;
      CONV3: if (ic_wrap) c3[och] <= relu(res);
      FC:    fco[och] <= res;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lenet_accelerator.sv
// Scoreboard bench for lenet_accelerator: directed weight/image sets with hand-derived logits,
// checked by a monitor on every done pulse.
module tb_lenet_accelerator;
  localparam int BW = 32;
  typedef logic [9:0][BW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic signed [BW-1:0] image          [27:0][27:0];
  logic signed [BW-1:0] conv1_kernel   [1:0][4:0][4:0];
  logic signed [BW-1:0] conv2_kernel   [1:0][1:0][4:0][4:0];
  logic signed [BW-1:0] conv3_kernel   [9:0][1:0][4:0][4:0];
  logic signed [BW-1:0] connect_matrix [9:0][9:0];
  logic signed [BW-1:0] output_vector  [9:0];
  logic busy, done;

  vec_t expq[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  lenet_accelerator #(.bitwidth(BW), .FRAC_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .image(image),
    .conv1_kernel(conv1_kernel), .conv2_kernel(conv2_kernel),
    .conv3_kernel(conv3_kernel), .connect_matrix(connect_matrix),
    .output_vector(output_vector), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic signed [BW-1:0] act,
                       input logic signed [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    vec_t e;
    if (!rst && done) begin
      done_cnt++;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1, want no pulse");
      end else begin
        e = expq.pop_front();
        for (int i = 0; i < 10; i++)
          check($sformatf("out[%0d]", i), output_vector[i], e[i]);
      end
    end
  end

  task automatic clear_all();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) image[r][c] = '0;
    for (int o = 0; o < 10; o++) begin
      for (int i = 0; i < 10; i++) connect_matrix[o][i] = '0;
      for (int i = 0; i < 2; i++)
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++) begin
            conv3_kernel[o][i][r][c] = '0;
            if (o < 2) conv2_kernel[o][i][r][c] = '0;
            if (o < 2 && i == 0) conv1_kernel[o][r][c] = '0;
          end
    end
  endtask

  task automatic set_identity();
    clear_all();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) image[r][c] = 256;
    conv1_kernel[0][2][2] = 256;
    conv2_kernel[0][0][2][2] = 256;
    conv3_kernel[0][0][2][2] = 256;
    for (int i = 0; i < 10; i++) connect_matrix[i][i] = 256;
  endtask

  task automatic run(input string name, input vec_t e);
    int  n0;
    bit  seen;
    @(negedge clk);
    n0 = done_cnt;
    expq.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_start"}, busy, 1);
    seen = 1'b0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done in 5000 cycles, want done", name);
      expq.delete();
    end else begin
      check({name, "_busy_at_done"}, busy, 0);
      @(negedge clk);
      check({name, "_done_width"}, done, 0);
      check({name, "_done_count"}, done_cnt - n0, 1);
    end
  endtask

  initial begin
    vec_t e;
    int   n0;
    rst = 1'b1;
    start = 1'b0;
    clear_all();
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    for (int i = 0; i < 10; i++) check($sformatf("reset_out[%0d]", i), output_vector[i], 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // zero image: any weights give zero logits
    for (int o = 0; o < 10; o++) begin
      for (int i = 0; i < 10; i++) connect_matrix[o][i] = $urandom;
      for (int i = 0; i < 2; i++)
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++) begin
            conv3_kernel[o][i][r][c] = $urandom;
            if (o < 2) conv2_kernel[o][i][r][c] = $urandom;
            if (o < 2 && i == 0) conv1_kernel[o][r][c] = $urandom;
          end
    end
    run("zero", '0);

    set_identity();
    e = '0;
    e[0] = 256;
    run("identity", e);

    // abort mid-run, previous logits must be cleared and no done may follow
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (400) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    for (int i = 0; i < 10; i++) check($sformatf("abort_out[%0d]", i), output_vector[i], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n0 = done_cnt;
    repeat (3000) @(negedge clk);
    check("abort_no_done", done_cnt - n0, 0);
    run("identity_after_reset", e);

    set_identity();
    conv1_kernel[0][2][2] = -256;
    run("relu_kill", '0);

    set_identity();
    connect_matrix[3][0] = 512;
    connect_matrix[7][0] = -768;
    e = '0;
    e[0] = 256;
    e[3] = 512;
    e[7] = -768;
    run("fc_routing", e);

    set_identity();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) image[r][c] = 32'h7FFF_FFFF;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) conv1_kernel[0][r][c] = 256;
    e = '0;
    e[0] = 32'h7FFF_FFFF;
    run("saturation", e);

    // bottom-right corner through channel 1 with [4][4] taps lands on logit 5
    clear_all();
    image[27][27] = 256;
    conv1_kernel[1][4][4] = 256;
    conv2_kernel[1][1][4][4] = 256;
    conv3_kernel[5][1][4][4] = 256;
    for (int i = 0; i < 10; i++) connect_matrix[i][i] = 256;
    e = '0;
    e[5] = 256;
    run("corner_ch1", e);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lenet_accelerator.md
Name: lenet_accelerator

Overview:
- Self-contained LeNet-style inference engine for one 28x28 single-channel image.
- Pipeline: conv1 (2 maps, same-pad) -> ReLU -> maxpool -> conv2 (2 maps) -> ReLU -> maxpool -> conv3 (10 outputs) -> ReLU -> 10x10 fully-connected layer.
- Weights and image arrive as unpacked-array ports. The result is a 10-entry signed logit vector.
- Sits under the top-level testbench/host wrapper that drives the image and weight arrays.

Parameters:
- bitwidth, 32, width of every signed data element: image, weights, intermediates, outputs.
- FRAC_BITS, 8, fixed-point fraction bits. Value 1.0 = 2^FRAC_BITS.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, reset, asynchronous, active-high.
- start, input, 1, one-cycle pulse that begins an inference.
- image, input, signed [bitwidth-1:0] [27:0][27:0], input pixels as [row][col].
- conv1_kernel, input, signed [bitwidth-1:0] [1:0][4:0][4:0], indexed [out][kr][kc].
- conv2_kernel, input, signed [bitwidth-1:0] [1:0][1:0][4:0][4:0], indexed [out][in][kr][kc].
- conv3_kernel, input, signed [bitwidth-1:0] [9:0][1:0][4:0][4:0], indexed [out][in][kr][kc].
- connect_matrix, input, signed [bitwidth-1:0] [9:0][9:0], indexed [out][in].
- output_vector, output, signed [bitwidth-1:0] [9:0], final logits.
- busy, output, 1, high while an inference runs.
- done, output, 1, one-cycle pulse when output_vector is updated.

Behaviour:
- Reset (async, rst=1): FSM goes to IDLE. output_vector = all 0, busy = 0, done = 0. Internal buffers need not be cleared.
- FSM states: IDLE -> CONV1 -> POOL1 -> CONV2 -> POOL2 -> CONV3 -> FC -> DONE -> IDLE.
- IDLE -> CONV1 on start=1. start while busy is ignored.
- Input arrays are read live, not snapshotted. The host holds them stable while busy=1.
- Every product is computed full-width (2*bitwidth) and accumulated in a 2*bitwidth+8 bit accumulator.
- At each output: arithmetic right shift by FRAC_BITS, then saturate to the signed bitwidth range.
- No biases anywhere.
- CONV1:
  - out[c][r][k] = sum over kr,kc of img[r+kr-2][k+kc-2] * conv1_kernel[c][kr][kc].
  - Out-of-range pixels read as 0. Result is 28x28x2.
  - ReLU: negatives -> 0.
- POOL1: 2x2 max, stride 2 -> 14x14x2.
- CONV2:
  - Valid convolution, summing both input channels -> 10x10x2.
  - Index as in[i][r+kr][k+kc]. ReLU.
- POOL2: 2x2 max -> 5x5x2.
- CONV3: valid 5x5 over both channels -> 10 scalars. ReLU.
- FC:
  - output[j] = sum over i of connect_matrix[j][i] * c3[i], with the same shift/saturate.
  - No activation.
- DONE:
  - output_vector is written with all 10 values simultaneously and done pulses high for exactly one cycle.
  - busy drops in the same cycle. Return to IDLE.
- output_vector holds its value until the next DONE or reset.
- Datapath: at minimum one MAC per clock. Intermediate maps are held in internal registers/RAM.
- Latency: start to done ≤ 60000 cycles and deterministic (identical for identical inputs).
- rst mid-inference aborts immediately with reset values. No done pulse for the aborted run.
- Saturation applies independently at every layer output, including intermediate maps.

Test Plan:
- Reset: rst=1 mid-run -> output_vector all 0, busy=0, done=0; after release, start gives a clean full run.
- Zero image, random weights -> done pulses once; output_vector all 0.
- Identity path:
  - Set image all 256; conv1_kernel[0][2][2]=256; conv2_kernel[0][0][2][2]=256; conv3_kernel[0][0][2][2]=256.
  - Set connect_matrix diagonal=256; all other weights 0.
  - Expect output_vector[0]=256, others 0.
- ReLU kill: as identity path but conv1_kernel[0][2][2]=-256 -> output_vector all 0.
- FC routing: identity path plus connect_matrix[3][0]=512 -> output_vector[3]=512, output_vector[0]=256, rest 0.
- Saturation: image all 0x7FFFFFFF, all 25 conv1_kernel[0] taps=256, rest as identity path -> output_vector[0]=0x7FFFFFFF, no wrap to negative.
